// File: rtl/jk_excitation_driver.sv
// Converts a requested target word into J/K excitation for a bank of W JK flops, tracking the bank in a shadow.
// Optional build macro VERIFY_EN: check bank readback i_q against the shadow in DONE and raise a sticky o_err.
module jk_excitation_driver #(
  parameter int W          = 4,
  parameter int SETTLE     = 1,
  parameter int USE_TOGGLE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_tgt,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_init,
  output logic [W-1:0] o_j,
  output logic [W-1:0] o_k,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_shadow,
  input  logic [W-1:0] i_q,
  output logic         o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t       state_q, state_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [W-1:0] diff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    diff     = i_tgt ^ shadow_q;

    case (state_q)
      S_IDLE: begin
        // Init wins over a simultaneous request: force every flop to reset.
        if (i_init) begin
          j_d      = '0;
          k_d      = '1;
          shadow_d = '0;
          state_d  = S_DRIVE;
        end else if (i_valid) begin
          shadow_d = i_tgt;
          if (diff == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRIVE;
            if (USE_TOGGLE != 0) begin
              j_d = diff;
              k_d = diff;
            end else begin
              j_d = diff & i_tgt;
              k_d = diff & ~i_tgt;
            end
          end
        end
      end
      S_DRIVE: begin
        j_d     = '0;
        k_d     = '0;
        cnt_d   = SETTLE_LAST;
        state_d = (SETTLE == 0) ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef VERIFY_EN
        if (i_q != shadow_q) begin
          err_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifndef VERIFY_EN
  logic unused_q;
  assign unused_q = ^i_q;
`endif

  assign o_j      = j_q;
  assign o_k      = k_q;
  assign o_shadow = shadow_q;
  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_err    = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver driving a behavioural bank of W JK flops.
module tb_jk_excitation_driver;

  localparam int W          = 4;
  localparam int SETTLE     = 1;
  localparam int USE_TOGGLE = 1;
`ifdef VERIFY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] shadow;
    int           busy;
    int           drives;
  } exp_t;

  logic         i_clk;
  logic         i_rst_n;
  logic [W-1:0] i_tgt;
  logic         i_valid;
  logic         o_ready;
  logic         i_init;
  logic [W-1:0] o_j;
  logic [W-1:0] o_k;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_shadow;
  logic [W-1:0] i_q;
  logic         o_err;

  logic [W-1:0] bank_q;
  logic [W-1:0] fault_mask;
  logic [W-1:0] model_shadow;
  exp_t         sb[$];
  int           err_count;
  int           check_count;
  int           busy_cnt;
  int           drive_cnt;
  logic [W-1:0] seen_j;
  logic [W-1:0] seen_k;

  jk_excitation_driver #(
    .W(W),
    .SETTLE(SETTLE),
    .USE_TOGGLE(USE_TOGGLE)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_tgt(i_tgt),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_init(i_init),
    .o_j(o_j),
    .o_k(o_k),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_shadow(o_shadow),
    .i_q(i_q),
    .o_err(o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // The external JK bank shares the clock and reset with the driver.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_q <= '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        case ({o_j[b], o_k[b]})
          2'b01:   bank_q[b] <= 1'b0;
          2'b10:   bank_q[b] <= 1'b1;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  assign i_q = bank_q ^ fault_mask;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one request, queues its expected outcome, and returns just after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] tgt, input logic init, input logic keep_valid);
    exp_t         e;
    logic [W-1:0] diff;
    int           budget;
    @(negedge i_clk);
    i_tgt   = tgt;
    i_init  = init;
    i_valid = 1'b1;
    if (init) begin
      e.j = '0; e.k = '1; e.shadow = '0; e.busy = 2 + SETTLE; e.drives = 1;
    end else begin
      diff     = tgt ^ model_shadow;
      e.shadow = tgt;
      if (diff == '0) begin
        e.j = '0; e.k = '0; e.busy = 1; e.drives = 0;
      end else begin
        e.j      = (USE_TOGGLE != 0) ? diff : (diff & tgt);
        e.k      = (USE_TOGGLE != 0) ? diff : (diff & ~tgt);
        e.busy   = 2 + SETTLE;
        e.drives = 1;
      end
    end
    model_shadow = e.shadow;
    sb.push_back(e);
    budget = 100;
    while (!o_ready && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    checkOutput("ready_wait", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_init = 1'b0;
    if (!keep_valid) i_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget;
    budget = 100;
    @(negedge i_clk);
    while ((sb.size() != 0 || !o_ready) && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    checkOutput("sb_drained", sb.size(), 32'd0);
  endtask

  // Monitor: pops the oldest expectation on every done pulse.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst_n) begin
      busy_cnt = 0; drive_cnt = 0; seen_j = '0; seen_k = '0;
    end else begin
      checkOutput("ready_vs_busy", {31'd0, o_ready}, {31'd0, ~o_busy});
      if (!o_busy) begin
        checkOutput("idle_done", {31'd0, o_done}, 32'd0);
        checkOutput("idle_jk", {o_j, o_k}, 32'd0);
        busy_cnt = 0; drive_cnt = 0; seen_j = '0; seen_k = '0;
      end else begin
        busy_cnt++;
        if ((o_j | o_k) != '0) begin
          drive_cnt++;
          seen_j = o_j;
          seen_k = o_k;
        end
        if (sb.size() == 0) begin
          checkOutput("busy_no_request", 32'd1, 32'd0);
        end else begin
          checkOutput("shadow_in_flight", o_shadow, sb[0].shadow);
          if (o_done) begin
            e = sb.pop_front();
            checkOutput("done_latency", busy_cnt, e.busy);
            checkOutput("drive_cycles", drive_cnt, e.drives);
            checkOutput("drive_j", seen_j, e.j);
            checkOutput("drive_k", seen_k, e.k);
            checkOutput("bank_q", bank_q, e.shadow);
          end
        end
      end
    end
  end

  initial begin
    err_count = 0; check_count = 0;
    i_rst_n = 1'b0; i_tgt = '0; i_valid = 1'b0; i_init = 1'b0;
    fault_mask = '0; model_shadow = '0;
    #3;
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("rst_jk", {o_j, o_k}, 32'd0);
    checkOutput("rst_shadow", o_shadow, 32'd0);
    checkOutput("rst_done", {31'd0, o_done}, 32'd0);
    checkOutput("rst_err", {31'd0, o_err}, 32'd0);
    #20;
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);

    applyStimulus(4'hA, 1'b0, 1'b0); waitIdle();
    applyStimulus(4'h6, 1'b0, 1'b0); waitIdle();
    applyStimulus(4'h6, 1'b0, 1'b0); waitIdle();
    applyStimulus(4'hF, 1'b0, 1'b0); waitIdle();
    checkOutput("bank_full", bank_q, 32'hF);
    applyStimulus(4'h5, 1'b1, 1'b0); waitIdle();
    checkOutput("init_bank", bank_q, 32'h0);

    // Valid held through a busy period must be taken only after done.
    applyStimulus(4'h9, 1'b0, 1'b1);
    applyStimulus(4'h3, 1'b0, 1'b0);
    waitIdle();

    for (int n = 0; n < 10; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 1'b0);
      waitIdle();
    end

    applyStimulus(4'h0, 1'b1, 1'b0); waitIdle();
    fault_mask = 4'h1;
    applyStimulus(4'h3, 1'b0, 1'b0); waitIdle();
    checkOutput("verify_err", {31'd0, o_err}, {31'd0, EXP_ERR});
    fault_mask = 4'h0;
    applyStimulus(4'hC, 1'b0, 1'b0); waitIdle();
    checkOutput("verify_err_sticky", {31'd0, o_err}, {31'd0, EXP_ERR});

    // Asynchronous reset while settling.
    applyStimulus(4'h5, 1'b0, 1'b0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("mid_rst_jk", {o_j, o_k}, 32'd0);
    checkOutput("mid_rst_shadow", o_shadow, 32'd0);
    checkOutput("mid_rst_done", {31'd0, o_done}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, o_err}, 32'd0);
    checkOutput("mid_rst_bank", bank_q, 32'd0);
    sb.delete();
    model_shadow = '0;
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    applyStimulus(4'h7, 1'b0, 1'b0); waitIdle();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
